// File: rtl/hack_fetch_unit_pkg.sv
// rtl/hack_fetch_unit_pkg.sv - shared widths and fetch FSM encodings for the Hack fetch unit
package hack_fetch_unit_pkg;

    localparam int HACK_ADDR_W     = 15;
    localparam int HACK_DATA_W     = 16;
    localparam int HACK_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_STALL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/hack_fetch_unit_if.sv
// rtl/hack_fetch_unit_if.sv - ROM, redirect and decode-side signals of the fetch unit
interface hack_fetch_unit_if
    import hack_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int DATA_W = HACK_DATA_W
);
    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ack;
    logic [DATA_W-1:0] rom_data;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;

    // fetch unit side
    modport master (
        output rom_req, rom_addr, instr_valid, instr_data, instr_pc,
        input  rom_ack, rom_data, jmp_valid, jmp_addr, instr_ready
    );

    // ROM / execute / decode side
    modport slave (
        input  rom_req, rom_addr, instr_valid, instr_data, instr_pc,
        output rom_ack, rom_data, jmp_valid, jmp_addr, instr_ready
    );
endinterface

// File: rtl/hack_fetch_unit_fetch_fifo.sv
// rtl/hack_fetch_unit_fetch_fifo.sv - small synchronous instruction buffer with flush
module fetch_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // occupancy after this edge; flush wins over any push/pop
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // storage and pointers; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_i) begin
                    mem_q[wr_ptr_q] <= data_i;
                    wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_i) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
        end
    end

    assign count_next_o = count_d;
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign head_o       = mem_q[rd_ptr_q];
endmodule

// File: rtl/hack_fetch_unit.sv
// rtl/hack_fetch_unit.sv - Hack CPU fetch stage: PC, ROM request FSM, jump redirect
module hack_fetch_unit
    import hack_fetch_unit_pkg::*;
#(
    parameter int ADDR_W     = HACK_ADDR_W,
    parameter int DATA_W     = HACK_DATA_W,
    parameter int FIFO_DEPTH = HACK_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    hack_fetch_unit_if.master bus
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              rom_req_q, rom_req_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic               ack;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               slot_free;
    logic [CNT_W-1:0]   count_next;
    logic [ENTRY_W-1:0] head;

    // an ack only counts against our own open request; a jump in the same
    // cycle discards the returning word and a pop under a jump is ignored
    assign ack       = rom_req_q && bus.rom_ack;
    assign fifo_push = ack && !drop_q && !bus.jmp_valid;
    assign fifo_pop  = !fifo_empty && bus.instr_ready && !bus.jmp_valid;
    assign slot_free = (count_next < CNT_W'(FIFO_DEPTH));

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (fifo_push),
        .data_i       ({pc_q, bus.rom_data}),
        .pop_i        (fifo_pop),
        .flush_i      (bus.jmp_valid),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_next_o (count_next),
        .head_o       (head)
    );

    // next PC, stale-response drop flag and request FSM
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        rom_req_d  = rom_req_q;
        rom_addr_d = rom_addr_q;

        if (bus.jmp_valid) begin
            pc_d = bus.jmp_addr;
        end else if (fifo_push) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        // a request still open across a jump must be allowed to finish, but its data is stale
        if (ack) begin
            drop_d = 1'b0;
        end else if (bus.jmp_valid && rom_req_q) begin
            drop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                state_d    = S_REQ;
                rom_req_d  = 1'b1;
                rom_addr_d = pc_d;
            end
            S_REQ: begin
                if (ack) begin
                    rom_addr_d = pc_d;
                    if (slot_free) begin
                        rom_req_d = 1'b1;
                    end else begin
                        state_d   = S_STALL;
                        rom_req_d = 1'b0;
                    end
                end
            end
            S_STALL: begin
                if (slot_free) begin
                    state_d    = S_REQ;
                    rom_req_d  = 1'b1;
                    rom_addr_d = pc_d;
                end
            end
            default: begin
                state_d   = S_IDLE;
                rom_req_d = 1'b0;
            end
        endcase
    end

    // registered FSM state, PC and ROM request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            drop_q     <= 1'b0;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // a request is only issued with a slot reserved, so a push never meets a full buffer
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

    assign bus.rom_req     = rom_req_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr_pc    = head[ENTRY_W-1:DATA_W];
    assign bus.instr_data  = head[DATA_W-1:0];
endmodule
